video_pattern_compositor: RTL
=============================

Name: video_pattern_compositor

Overview:
- Parametrised successor to the fixed 24-band test bar and camera split used in the HDMI path.
- Sits between the video timing generator and the DVI/TMDS transmitter, in the pixel-clock domain.
- Generates one of four selectable test patterns and composites camera RGB565 below a programmable split line.
- Produces a registered, latency-matched hs/vs/de/RGB stream.

Parameters:
H_ACTIVE, 1280, active pixels per line
V_ACTIVE, 720, active lines per frame
BAND_NUM, 24, walking-bit band count; BAND_NUM <= 3*DATA_W
DATA_W, 8, output bits per colour channel
GRID_SHIFT, 5, grid pitch = 2**GRID_SHIFT pixels

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous reset, active-high
in_hs  in  1  timing hsync
in_vs  in  1  timing vsync, active-high
in_de  in  1  timing data enable
in_x  in  11  active x, valid when in_de
in_y  in  11  active y, valid when in_de
cam_r  in  5  camera red, aligned with in_de
cam_g  in  6  camera green
cam_b  in  5  camera blue
mode  in  2  pattern select: 0 walking-bit, 1 eight-colour bars, 2 scrolling gradient, 3 grid
cam_en  in  1  enable camera composite
split_y  in  11  camera is shown on lines with y > split_y
out_hs  out  1  delayed hs
out_vs  out  1  delayed vs
out_de  out  1  delayed de
out_r  out  DATA_W  red
out_g  out  DATA_W  green
out_b  out  DATA_W  blue
frame_cnt  out  8  frame counter

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: all outputs 0; frame_cnt 0; shadow mode 0; shadow cam_en 0; shadow split_y V_ACTIVE/2; band counters 0.
- Latency: fixed 2 cycles. out_* at cycle N+2 correspond to in_*/cam_* at cycle N. hs/vs/de pass through a matching 2-stage delay.
- Shadow registers: mode, cam_en and split_y are sampled only on the in_vs rising edge (vs high now, low last cycle). Mid-frame changes have no effect until the next frame.
- frame_cnt: increments on each in_vs rising edge and wraps 255 -> 0.
- Band tracking (no divider):
  - BW = H_ACTIVE/BAND_NUM; BW8 = H_ACTIVE/8.
  - band_pos and band_idx clear on each in_de rising edge.
  - While in_de is high, band_pos increments. At band_pos == BW-1, band_pos clears and band_idx increments, saturating at BAND_NUM-1; the remainder pixels belong to the last band.
  - An identical bar_pos/bar_idx pair uses BW8 and saturates at 7.
- Mode 0: only bit (3*DATA_W-1-band_idx) of {r,g,b} is set.
- Mode 1: bar_idx 0..7 maps to white, yellow, cyan, green, magenta, red, blue, black. Channel full scale is all ones.
- Mode 2: r = (x + frame_cnt) mod 2**DATA_W; g = y mod 2**DATA_W; b = frame_cnt truncated or zero-extended to DATA_W.
- Mode 3: white where x[GRID_SHIFT-1:0]==0 or y[GRID_SHIFT-1:0]==0, else black.
- Composite: if shadow cam_en is set and y > shadow split_y, the camera pixel replaces the pattern. Each channel is MSB-replicated to DATA_W, e.g. 5-bit v -> {v, v[4:2]} for DATA_W=8.
- Blanking: when the delayed de is low, out_r/g/b = 0.
- Reset mid-frame: outputs go to 0 on the next cycle. After release, output stays blank until the next in_de rising edge; frame_cnt resumes from 0 at the next vs rising edge.
- Simultaneous vs edge and mode change: the value present on that cycle is captured.

Optional Feature:
PATTERN_BORDER_EN
- Defined: pixels with x==0, x==H_ACTIVE-1, y==0 or y==V_ACTIVE-1 are forced to full white, overriding pattern and camera. Latency is unchanged.
- Undefined: no border logic; behaviour is exactly as above.

Test Plan:
- rst held 4 cycles with toggling inputs -> all outputs 0 and frame_cnt 0; after release, first vs rising edge -> frame_cnt 1.
- Mode 0, default params, line y=10:
  - x=0 -> rgb 24'h800000, seen 2 cycles after in_de.
  - x=53 -> 24'h400000.
  - x=1218 -> 24'h000002.
  - x=1271 and x=1279 -> 24'h000001.
  - de low -> 0.
- Mode written 0 -> 1 mid-frame -> output stays mode 0 until the next vs edge; next frame x=0 -> FFFFFF, x=160 -> FFFF00, x=1279 -> 000000.
- cam_en=1, split_y=360, cam_r=5'h10, cam_g=6'h3F, cam_b=0:
  - y=360 -> pattern pixel.
  - y=361 -> r=8'h84, g=8'hFF, b=0.
- Mode 2: drive 256 vs pulses -> frame_cnt wraps to 0. With frame_cnt=3 at x=254 -> r=1; y=300 -> g=8'h2C.
- With PATTERN_BORDER_EN defined and cam_en=1:
  - x=0, y=500 -> FFFFFF.
  - x=1, y=500 -> camera pixel.
  - With the macro undefined, x=0, y=500 -> camera pixel.

Source files
------------

// File: rtl/video_pattern_compositor.sv
// Test-pattern generator with a camera RGB565 composite below a split line; 2-cycle latency.
// Optional macro PATTERN_BORDER_EN forces a white one-pixel frame border.
module video_pattern_compositor #(
  parameter int unsigned H_ACTIVE   = 1280,
  parameter int unsigned V_ACTIVE   = 720,
  parameter int unsigned BAND_NUM   = 24,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned GRID_SHIFT = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_hs,
  input  logic              in_vs,
  input  logic              in_de,
  input  logic [10:0]       in_x,
  input  logic [10:0]       in_y,
  input  logic [4:0]        cam_r,
  input  logic [5:0]        cam_g,
  input  logic [4:0]        cam_b,
  input  logic [1:0]        mode,
  input  logic              cam_en,
  input  logic [10:0]       split_y,
  output logic              out_hs,
  output logic              out_vs,
  output logic              out_de,
  output logic [DATA_W-1:0] out_r,
  output logic [DATA_W-1:0] out_g,
  output logic [DATA_W-1:0] out_b,
  output logic [7:0]        frame_cnt
);

  localparam int unsigned BW  = H_ACTIVE / BAND_NUM;
  localparam int unsigned BW8 = H_ACTIVE / 8;
  localparam int unsigned BPW = (BW > 1) ? $clog2(BW) : 1;
  localparam int unsigned BIW = (BAND_NUM > 1) ? $clog2(BAND_NUM) : 1;
  localparam int unsigned RPW = (BW8 > 1) ? $clog2(BW8) : 1;
  localparam int unsigned CW  = 3 * DATA_W;
  localparam int unsigned SW  = DATA_W + 12;

  logic           vs_q, de_q, armed;
  logic [1:0]     mode_s;
  logic           cam_en_s;
  logic [10:0]    split_s;
  logic [BPW-1:0] band_pos;
  logic [BIW-1:0] band_idx;
  logic [RPW-1:0] bar_pos;
  logic [2:0]     bar_idx;
  logic           hs1, vs1, de1;
  logic [CW-1:0]  pix1;

  logic           vs_rise_c, de_rise_c, pix_valid_c;
  logic [BPW-1:0] cur_band_pos_c;
  logic [BIW-1:0] cur_band_idx_c;
  logic [RPW-1:0] cur_bar_pos_c;
  logic [2:0]     cur_bar_idx_c;
  logic [SW-1:0]  grad_sum_c;
  logic [CW-1:0]  pat_c;

  // Replicate the source MSBs downward to fill a DATA_W-wide channel.
  function automatic logic [DATA_W-1:0] expand(input logic [5:0] v, input int w);
    logic [DATA_W-1:0] e;
    e = '0;
    for (int i = 0; i < int'(DATA_W); i++) e[DATA_W-1-i] = v[w-1-(i%w)];
    return e;
  endfunction

  assign vs_rise_c   = in_vs & ~vs_q;
  assign de_rise_c   = in_de & ~de_q;
  assign pix_valid_c = in_de & (armed | de_rise_c);

  // Counters describe the pixel on the bus now; a de rising edge restarts them at zero.
  assign cur_band_pos_c = de_rise_c ? '0 : band_pos;
  assign cur_band_idx_c = de_rise_c ? '0 : band_idx;
  assign cur_bar_pos_c  = de_rise_c ? '0 : bar_pos;
  assign cur_bar_idx_c  = de_rise_c ? '0 : bar_idx;
  assign grad_sum_c     = SW'(in_x) + SW'(frame_cnt);

  always_comb begin
    pat_c = '0;
    case (mode_s)
      2'd0: pat_c = {1'b1, {(CW-1){1'b0}}} >> cur_band_idx_c;
      2'd1: pat_c = {{DATA_W{~cur_bar_idx_c[1]}}, {DATA_W{~cur_bar_idx_c[2]}},
                     {DATA_W{~cur_bar_idx_c[0]}}};
      2'd2: pat_c = {DATA_W'(grad_sum_c), DATA_W'(in_y), DATA_W'(frame_cnt)};
      default: pat_c = ((in_x[GRID_SHIFT-1:0] == '0) || (in_y[GRID_SHIFT-1:0] == '0)) ?
                       '1 : '0;
    endcase
    if (cam_en_s && (in_y > split_s))
      pat_c = {expand({1'b0, cam_r}, 5), expand(cam_g, 6), expand({1'b0, cam_b}, 5)};
`ifdef PATTERN_BORDER_EN
    if ((in_x == 11'd0) || (in_x == 11'(H_ACTIVE-1)) ||
        (in_y == 11'd0) || (in_y == 11'(V_ACTIVE-1)))
      pat_c = '1;
`endif
    if (!pix_valid_c) pat_c = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q      <= 1'b0;
      de_q      <= 1'b1;
      armed     <= 1'b0;
      mode_s    <= 2'd0;
      cam_en_s  <= 1'b0;
      split_s   <= 11'(V_ACTIVE/2);
      frame_cnt <= 8'd0;
      band_pos  <= '0;
      band_idx  <= '0;
      bar_pos   <= '0;
      bar_idx   <= '0;
      hs1       <= 1'b0;
      vs1       <= 1'b0;
      de1       <= 1'b0;
      pix1      <= '0;
      out_hs    <= 1'b0;
      out_vs    <= 1'b0;
      out_de    <= 1'b0;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
    end else begin
      vs_q <= in_vs;
      de_q <= in_de;
      if (de_rise_c) armed <= 1'b1;
      if (vs_rise_c) begin
        mode_s    <= mode;
        cam_en_s  <= cam_en;
        split_s   <= split_y;
        frame_cnt <= frame_cnt + 8'd1;
      end
      if (in_de) begin
        if (cur_band_pos_c == BPW'(BW-1)) begin
          band_pos <= '0;
          band_idx <= (cur_band_idx_c == BIW'(BAND_NUM-1)) ? cur_band_idx_c
                                                           : cur_band_idx_c + BIW'(1);
        end else begin
          band_pos <= cur_band_pos_c + BPW'(1);
          band_idx <= cur_band_idx_c;
        end
        if (cur_bar_pos_c == RPW'(BW8-1)) begin
          bar_pos <= '0;
          bar_idx <= (cur_bar_idx_c == 3'd7) ? cur_bar_idx_c : cur_bar_idx_c + 3'd1;
        end else begin
          bar_pos <= cur_bar_pos_c + RPW'(1);
          bar_idx <= cur_bar_idx_c;
        end
      end
      hs1    <= in_hs;
      vs1    <= in_vs;
      de1    <= in_de;
      pix1   <= pat_c;
      out_hs <= hs1;
      out_vs <= vs1;
      out_de <= de1;
      out_r  <= de1 ? pix1[CW-1 -: DATA_W]       : '0;
      out_g  <= de1 ? pix1[2*DATA_W-1 -: DATA_W] : '0;
      out_b  <= de1 ? pix1[DATA_W-1:0]           : '0;
    end
  end

endmodule
